// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the division sequencer.
// Contents:
//   SETTLE_CYCLES_DEFAULT - default number of cycles the external divider
//                           core gets to settle (legal 1..15, 4-bit counter)
//   state_t               - sequencer FSM state encoding
package div_sequencer_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, 32-bit, purely combinational.
// Ports:
//   din  - value to pass through or negate
//   neg  - 1: dout = -din, 0: dout = din
//   dout - result (0x80000000 negates to itself, which the callers rely on
//          when taking magnitudes)
module div_sign_fix (
    input  logic [31:0] din,
    input  logic        neg,
    output logic [31:0] dout
);

    assign dout = neg ? (~din + 32'd1) : din;

endmodule

// File: rtl/div_sequencer.sv
// Signed 32-bit division sequencer around an external unsigned divider core.
// Operands are reduced to magnitudes, held stable on div_a/div_b for a
// multicycle settle window, and the core's unsigned quotient/remainder is
// sign-corrected. Divide-by-zero and |divisor| = 0x80000000 bypass the core.
// Ports:
//   clock    - single clock, rising edge
//   clear    - asynchronous active-high reset
//   start    - one-cycle divide request, sampled only in IDLE
//   dividend - signed dividend, sampled with start
//   divisor  - signed divisor, sampled with start
//   div_a    - dividend magnitude to the divider core
//   div_b    - divisor magnitude to the divider core
//   div_q    - core result {quotient[63:32], remainder[31:0]}, unsigned
//   busy     - operation in flight (LOAD, WAIT, FIXUP)
//   done     - one-cycle completion pulse
//   lo       - signed quotient
//   hi       - signed remainder
//   div_zero - completed operation had a zero divisor
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_q,
    output logic        busy,
    output logic        done,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        div_zero
);

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic [31:0] a_reg, b_reg;
    logic        a_neg_reg, b_neg_reg;
    logic [31:0] div_a_reg, div_b_reg;
    logic [31:0] lo_reg, hi_reg;
    logic        div_zero_reg;

    logic [31:0] mag_a, mag_b;
    logic [31:0] q_fixed, r_fixed;
    logic [31:0] lo_next, hi_next;
    logic        div_zero_next;

    // Magnitude path: operands into the core.
    div_sign_fix u_mag_a (.din(a_reg), .neg(a_neg_reg), .dout(mag_a));
    div_sign_fix u_mag_b (.din(b_reg), .neg(b_neg_reg), .dout(mag_b));

    // Fixup path: quotient takes the XOR of signs, remainder follows dividend.
    div_sign_fix u_fix_q (.din(div_q[63:32]), .neg(a_neg_reg ^ b_neg_reg), .dout(q_fixed));
    div_sign_fix u_fix_r (.din(div_q[31:0]),  .neg(a_neg_reg),             .dout(r_fixed));

    // ---------------- FSM state register ----------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- FSM next-state / outputs ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                cnt_next   = 4'(SETTLE_CYCLES);
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter is loaded with SETTLE_CYCLES, so leaving on 1
                // gives exactly SETTLE_CYCLES cycles in WAIT.
                busy     = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = ST_FIXUP;
            end
            ST_FIXUP: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- Result selection ----------------
    always_comb begin
        lo_next       = q_fixed;
        hi_next       = r_fixed;
        div_zero_next = 1'b0;
        if (b_reg == 32'd0) begin
            lo_next       = 32'hFFFF_FFFF;
            hi_next       = a_reg;
            div_zero_next = 1'b1;
        end else if (b_reg == MIN_NEG) begin
            // The core is not asked to handle a 2^31 divisor; the only
            // dividend with magnitude >= 2^31 is MIN_NEG itself.
            lo_next = (a_reg == MIN_NEG) ? 32'd1 : 32'd0;
            hi_next = (a_reg == MIN_NEG) ? 32'd0 : a_reg;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            div_a_reg    <= 32'd0;
            div_b_reg    <= 32'd0;
            lo_reg       <= 32'd0;
            hi_reg       <= 32'd0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= dividend;
                        b_reg     <= divisor;
                        a_neg_reg <= dividend[31];
                        b_neg_reg <= divisor[31];
                    end
                end
                ST_LOAD: begin
                    div_a_reg <= mag_a;
                    div_b_reg <= mag_b;
                end
                ST_FIXUP: begin
                    lo_reg       <= lo_next;
                    hi_reg       <= hi_next;
                    div_zero_reg <= div_zero_next;
                end
                default: ;
            endcase
        end
    end

    assign div_a    = div_a_reg;
    assign div_b    = div_b_reg;
    assign lo       = lo_reg;
    assign hi       = hi_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer (SETTLE_CYCLES = 4). Stimulus pushes
// hand-computed results into a queue; a monitor pops on every done pulse
// and checks result, latency and busy duration.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor  = 32'd0;
    logic [31:0] div_a, div_b;
    logic [63:0] div_q;
    logic        busy, done, div_zero;
    logic [31:0] lo, hi;

    div_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clock(clock), .clear(clear), .start(start),
        .dividend(dividend), .divisor(divisor),
        .div_a(div_a), .div_b(div_b), .div_q(div_q),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    // Reference unsigned divider core; returns junk where the sequencer
    // must not use the core result.
    always_comb begin
        if (div_b == 32'd0 || div_b == 32'h8000_0000)
            div_q = 64'hDEAD_BEEF_CAFE_F00D;
        else
            div_q = {div_a / div_b, div_a % div_b};
    end

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_done = 0;
    int   busy_run = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares on each done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div_zero", 32'(div_zero), 32'(e.dz));
                chk("latency", 32'(cyc - e.start_cyc), 32'd7);
                chk("busy_cycles", 32'(busy_run), 32'd6);
                $display("txn: lo=0x%08h hi=0x%08h dz=%0b lat=%0d busy=%0d",
                         lo, hi, div_zero, cyc - e.start_cyc, busy_run);
            end
        end
        busy_run = busy ? busy_run + 1 : 0;
    end

    // Called at a negedge: presents start for one cycle and records expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.lo = elo; e.hi = ehi; e.dz = edz; e.start_cyc = cyc;
        exp_q.push_back(e);
        n_push++;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #2;
            if (exp_q.size() == 0) break;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
        @(negedge clock);
        issue(a, b, elo, ehi, edz);
        wait_done();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_done"},     32'(done), 32'd0);
        chk({tag, "_div_zero"}, 32'(div_zero), 32'd0);
        chk({tag, "_lo"},       lo, 32'd0);
        chk({tag, "_hi"},       hi, 32'd0);
        chk({tag, "_div_a"},    div_a, 32'd0);
        chk({tag, "_div_b"},    div_b, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_zero_outputs("reset");
        @(negedge clock);
        clear = 1'b0;

        // Directed vectors
        run_op(32'd100,        32'd7,            32'd14,          32'd2,          1'b0);
        run_op(-32'sd100,      32'd7,            32'hFFFF_FFF2,   32'hFFFF_FFFE,  1'b0);
        run_op(32'd100,        -32'sd7,          32'hFFFF_FFF2,   32'd2,          1'b0);
        run_op(32'd100,        32'd0,            32'hFFFF_FFFF,   32'd100,        1'b1);
        run_op(32'd9,          32'd3,            32'd3,           32'd0,          1'b0);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,    32'h8000_0000,   32'd0,          1'b0);
        run_op(32'd5,          32'h8000_0000,    32'd0,           32'd5,          1'b0);
        run_op(32'h8000_0000,  32'h8000_0000,    32'd1,           32'd0,          1'b0);
        run_op(-32'sd7,        32'h8000_0000,    32'd0,           32'hFFFF_FFF9,  1'b0);
        run_op(32'h8000_0000,  32'd0,            32'hFFFF_FFFF,   32'h8000_0000,  1'b1);

        // Clear in the 2nd WAIT cycle aborts with no done
        @(negedge clock);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clock); start = 1'b0;   // LOAD
        @(negedge clock);                 // WAIT 1
        @(negedge clock);                 // WAIT 2
        clear = 1'b1;
        #1;
        chk_zero_outputs("abort");
        @(negedge clock);
        clear = 1'b0;
        issue(32'd20, 32'd3, 32'd6, 32'd2, 1'b0);
        wait_done();

        // start re-pulsed while busy and during done is ignored
        @(negedge clock);
        issue(32'd50, -32'sd6, 32'hFFFF_FFF8, 32'd2, 1'b0);
        dividend = 32'd1; divisor = 32'd1; start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_done();
        start = 1'b1;                     // DONE cycle
        dividend = 32'd77; divisor = 32'd7;
        @(negedge clock); start = 1'b0;
        repeat (12) @(negedge clock);
        chk("result_held_lo", lo, 32'hFFFF_FFF8);
        chk("result_held_hi", hi, 32'd2);

        chk("done_count", 32'(n_done), 32'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
